// File: rtl/modinv_helper_reduce_update_pkg.sv
// Shared constants and helpers for the modular-invertor reduce/update write-back stage.
// Cycle formulas are functions so they follow the buffer size chosen per instance.
package modinv_helper_reduce_update_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Process counter runs 0..N+2: one accept cycle, N reads, RAM latency, completion.
    function automatic int proc_num_cycles(input int num_words);
        return num_words + 3;
    endfunction

    function automatic int wr_first_cnt();
        return 2;
    endfunction

    function automatic int wr_last_cnt(input int num_words);
        return num_words + 1;
    endfunction

endpackage

// File: rtl/modinv_helper_reduce_update.sv
// Write-back stage of the modular-invertor reduction step: copies U (s/2) or V ((s+q)/2)
// into S word-serially and reports the decremented k plus zero/odd flags of the new s.
module modinv_helper_reduce_update
    import modinv_helper_reduce_update_pkg::*;
#(
    parameter int BUFFER_NUM_WORDS = 9,
    parameter int BUFFER_ADDR_BITS = 4,
    parameter int K_NUM_BITS       = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ena,
    output logic                        rdy,
    input  logic                        s_is_odd,
    input  logic [K_NUM_BITS-1:0]       k_in,
    output logic [K_NUM_BITS-1:0]       k_out,
    output logic                        s_is_zero,
    output logic                        s_lsb,
    output logic [BUFFER_ADDR_BITS-1:0] u_addr,
    input  logic [31:0]                 u_din,
    output logic [BUFFER_ADDR_BITS-1:0] v_addr,
    input  logic [31:0]                 v_din,
    output logic [BUFFER_ADDR_BITS-1:0] s_addr,
    output logic                        s_wren,
    output logic [31:0]                 s_dout
);

    localparam int CNT_W = clog2(proc_num_cycles(BUFFER_NUM_WORDS));

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(proc_num_cycles(BUFFER_NUM_WORDS) - 1);
    localparam logic [CNT_W-1:0] WR_FIRST    = CNT_W'(wr_first_cnt());
    localparam logic [CNT_W-1:0] WR_LAST     = CNT_W'(wr_last_cnt(BUFFER_NUM_WORDS));
    localparam logic [CNT_W-1:0] RD_INC_LAST = CNT_W'(BUFFER_NUM_WORDS - 1);

    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [BUFFER_ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
    logic [BUFFER_ADDR_BITS-1:0] wr_addr_q;
    logic                        sel_q, sel_d;
    logic [K_NUM_BITS-1:0]       k_lat_q, k_lat_d;
    logic                        zacc_q, zacc_d;
    logic                        lsb_acc_q, lsb_acc_d;
    logic [K_NUM_BITS-1:0]       k_out_q, k_out_d;
    logic                        s_is_zero_q, s_is_zero_d;
    logic                        s_lsb_q, s_lsb_d;

    assign rdy       = (cnt_q == '0);
    assign u_addr    = rd_addr_q;
    assign v_addr    = rd_addr_q;
    assign s_addr    = wr_addr_q;
    assign s_wren    = (cnt_q >= WR_FIRST) && (cnt_q <= WR_LAST);
    // RAM read data goes straight to S; the write address pipe absorbs the read latency.
    assign s_dout    = sel_q ? v_din : u_din;
    assign k_out     = k_out_q;
    assign s_is_zero = s_is_zero_q;
    assign s_lsb     = s_lsb_q;

    always_comb begin
        cnt_d       = cnt_q;
        rd_addr_d   = rd_addr_q;
        sel_d       = sel_q;
        k_lat_d     = k_lat_q;
        zacc_d      = zacc_q;
        lsb_acc_d   = lsb_acc_q;
        k_out_d     = k_out_q;
        s_is_zero_d = s_is_zero_q;
        s_lsb_d     = s_lsb_q;

        if (rdy) begin
            if (ena) begin
                cnt_d   = CNT_W'(1);
                sel_d   = s_is_odd;
                k_lat_d = k_in;
                zacc_d  = 1'b0;
            end
        end else begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
            if (cnt_q <= RD_INC_LAST) begin
                rd_addr_d = rd_addr_q + BUFFER_ADDR_BITS'(1);
            end
            if (cnt_q == CNT_LAST) begin
                rd_addr_d   = '0;
                s_is_zero_d = ~zacc_q;
                s_lsb_d     = lsb_acc_q;
                k_out_d     = (k_lat_q == '0) ? '0 : k_lat_q - K_NUM_BITS'(1);
            end
        end

        // s_wren is never high while idle, so this cannot collide with the accept clear.
        if (s_wren) begin
            zacc_d = zacc_q | (|s_dout);
            if (wr_addr_q == '0) begin
                lsb_acc_d = s_dout[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            sel_q       <= 1'b0;
            k_lat_q     <= '0;
            zacc_q      <= 1'b0;
            lsb_acc_q   <= 1'b0;
            k_out_q     <= '0;
            s_is_zero_q <= 1'b0;
            s_lsb_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= rd_addr_q;
            sel_q       <= sel_d;
            k_lat_q     <= k_lat_d;
            zacc_q      <= zacc_d;
            lsb_acc_q   <= lsb_acc_d;
            k_out_q     <= k_out_d;
            s_is_zero_q <= s_is_zero_d;
            s_lsb_q     <= s_lsb_d;
        end
    end

endmodule

// File: tb/tb_modinv_helper_reduce_update.sv
// Directed bench for the reduce/update write-back stage with U/V/S RAM models.
module tb_modinv_helper_reduce_update;

    localparam int N  = 9;
    localparam int AW = 4;
    localparam int KW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena;
    logic          rdy;
    logic          s_is_odd;
    logic [KW-1:0] k_in;
    logic [KW-1:0] k_out;
    logic          s_is_zero;
    logic          s_lsb;
    logic [AW-1:0] u_addr;
    logic [31:0]   u_din;
    logic [AW-1:0] v_addr;
    logic [31:0]   v_din;
    logic [AW-1:0] s_addr;
    logic          s_wren;
    logic [31:0]   s_dout;

    logic [31:0] u_mem [16];
    logic [31:0] v_mem [16];
    logic [31:0] s_mem [16];
    logic        s_clr;

    int errors = 0;
    int checks = 0;
    int edges;
    int wcnt;
    int wfirst;
    int wlast;

    modinv_helper_reduce_update #(
        .BUFFER_NUM_WORDS(N),
        .BUFFER_ADDR_BITS(AW),
        .K_NUM_BITS(KW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ena(ena),
        .rdy(rdy),
        .s_is_odd(s_is_odd),
        .k_in(k_in),
        .k_out(k_out),
        .s_is_zero(s_is_zero),
        .s_lsb(s_lsb),
        .u_addr(u_addr),
        .u_din(u_din),
        .v_addr(v_addr),
        .v_din(v_din),
        .s_addr(s_addr),
        .s_wren(s_wren),
        .s_dout(s_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        u_din <= u_mem[u_addr];
        v_din <= v_mem[v_addr];
        if (s_clr) begin
            for (int i = 0; i < 16; i++) s_mem[i] <= 32'hDEAD_BEEF;
        end else if (s_wren) begin
            s_mem[s_addr] <= s_dout;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_s();
        s_clr = 1'b1;
        step();
        s_clr = 1'b0;
    endtask

    // mode 0: plain; 1: ena pulse at cnt=4; 2: ena held high; 3: s_is_odd/k_in toggled mid-run
    task automatic run(input bit odd, input logic [KW-1:0] k, input int mode);
        int c;
        ena      = 1'b1;
        s_is_odd = odd;
        k_in     = k;
        step();
        edges = 1;
        c     = 1;
        if (mode != 2) ena = 1'b0;
        wcnt = 0; wfirst = 0; wlast = 0;
        while (!rdy && edges < 40) begin
            if (s_wren) begin
                if (wcnt == 0) wfirst = c;
                wlast = c;
                wcnt++;
            end
            if (mode == 1) ena = (c == 4);
            if (mode == 3 && (c == 3 || c == 6)) begin
                s_is_odd = ~s_is_odd;
                k_in     = k_in + 1'b1;
            end
            step();
            edges++;
            c++;
        end
        if (mode == 1) ena = 1'b0;
    endtask

    task automatic check_run(input string tag, input bit src_v, input logic [KW-1:0] exp_k,
                             input bit exp_zero, input bit exp_lsb);
        chk({tag, "_edges"}, edges, 12);
        chk({tag, "_wren_pulses"}, wcnt, N);
        chk({tag, "_wren_first"}, wfirst, 2);
        chk({tag, "_wren_last"}, wlast, N + 1);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_S%0d", tag, i), s_mem[i], src_v ? v_mem[i] : u_mem[i]);
        end
        chk({tag, "_k_out"}, 32'(k_out), 32'(exp_k));
        chk({tag, "_s_is_zero"}, 32'(s_is_zero), 32'(exp_zero));
        chk({tag, "_s_lsb"}, 32'(s_lsb), 32'(exp_lsb));
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; s_is_odd = 1'b0; k_in = '0; s_clr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            u_mem[i] = 32'h1000_0000 + i;
            v_mem[i] = 32'hFFFF_FFFF;
        end
        step();
        step();
        rst = 1'b0;
        chk("reset_rdy", 32'(rdy), 1);
        chk("reset_wren", 32'(s_wren), 0);
        chk("reset_k_out", 32'(k_out), 0);
        chk("reset_zero", 32'(s_is_zero), 0);
        chk("reset_lsb", 32'(s_lsb), 0);
        chk("reset_u_addr", 32'(u_addr), 0);

        // U source, plain data
        clear_s();
        run(1'b0, 10'd5, 0);
        check_run("t1", 1'b0, 10'd4, 1'b0, 1'b0);

        // V source, odd word 0, k saturates at 0
        v_mem[0] = 32'h3;
        for (int i = 1; i < 16; i++) v_mem[i] = 32'h0;
        clear_s();
        run(1'b1, 10'd0, 0);
        check_run("t2", 1'b1, 10'd0, 1'b0, 1'b1);

        // all-zero U
        for (int i = 0; i < 16; i++) u_mem[i] = 32'h0;
        clear_s();
        run(1'b0, 10'd7, 0);
        check_run("t3", 1'b0, 10'd6, 1'b1, 1'b0);

        // reset at cnt=5 with a simultaneous ena that must be dropped
        ena = 1'b1; s_is_odd = 1'b1; k_in = 10'd9;
        step();
        ena = 1'b0;
        chk("t4_busy", 32'(rdy), 0);
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1; ena = 1'b1;
        step();
        rst = 1'b0; ena = 1'b0;
        chk("t4_rdy", 32'(rdy), 1);
        chk("t4_wren", 32'(s_wren), 0);
        chk("t4_k_out", 32'(k_out), 0);
        chk("t4_zero", 32'(s_is_zero), 0);
        chk("t4_lsb", 32'(s_lsb), 0);
        step();
        chk("t4_rdy_hold", 32'(rdy), 1);

        // only the top bit of the last word set
        u_mem[8] = 32'h8000_0000;
        clear_s();
        run(1'b0, 10'd3, 0);
        check_run("t5", 1'b0, 10'd2, 1'b0, 1'b0);

        // ena pulse mid-run is ignored
        for (int i = 0; i < 16; i++) u_mem[i] = 32'hA5A5_0001 + (i << 8);
        clear_s();
        run(1'b0, 10'd10, 1);
        check_run("t6", 1'b0, 10'd9, 1'b0, 1'b1);

        // ena held high: run unaffected, next run starts on the rdy edge
        for (int i = 0; i < 16; i++) v_mem[i] = 32'h0F0F_0000 + i;
        clear_s();
        run(1'b1, 10'd1, 2);
        check_run("t7", 1'b1, 10'd0, 1'b0, 1'b0);
        step();
        chk("t7_b2b_accept", 32'(rdy), 0);
        ena = 1'b0;
        edges = 1;
        while (!rdy && edges < 40) begin
            step();
            edges++;
        end
        chk("t7_b2b_edges", edges, 12);
        chk("t7_b2b_k_out", 32'(k_out), 0);

        // source and k latched at accept despite mid-run toggles
        clear_s();
        run(1'b0, 10'd20, 3);
        check_run("t8", 1'b0, 10'd19, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
